// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU memory bus: a word array plus one memory-mapped
// output register, answering each accepted request after WAIT_STATES wait cycles.
module mem_bus_responder #(
   parameter int                ADDR_W      = 8,
   parameter int                DATA_W      = 16,
   parameter int                WAIT_STATES = 1,
   parameter logic [ADDR_W-1:0] IO_ADDR     = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_rw,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_busy,
   output logic [DATA_W-1:0] io_out,
   output logic              io_strobe
);

   if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
      $error("mem_bus_responder: WAIT_STATES=%0d is outside 0..7", WAIT_STATES);
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // Word array; left unreset so benches can preload it from a hex image.
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   logic              acc_rw;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              do_access;

   // With zero wait states the access happens on the accept edge, so it must use the live bus.
   always_comb begin
      acc_rw    = rw_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      do_access = 1'b0;
      if (state == S_IDLE) begin
         acc_rw    = mem_rw;
         acc_addr  = mem_addr;
         acc_wdata = mem_wdata;
         do_access = mem_req && (WAIT_STATES == 0);
      end else if (state == S_WAIT) begin
         do_access = (cnt == 3'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_access && acc_rw && (acc_addr != IO_ADDR))
         mem[acc_addr] <= acc_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_rdata <= '0;
         mem_ready <= 1'b0;
         mem_busy  <= 1'b0;
         io_out    <= '0;
         io_strobe <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         io_strobe <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_req) begin
                  rw_q     <= mem_rw;
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  mem_busy <= 1'b1;
                  if (WAIT_STATES == 0) begin
                     state     <= S_RESP;
                     mem_ready <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 3'(WAIT_STATES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 3'd0) begin
                  state     <= S_RESP;
                  mem_ready <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_RESP: begin
               state    <= S_IDLE;
               mem_busy <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               mem_busy <= 1'b0;
            end
         endcase

         // Read data and the IO register update on the same edge that enters RESP.
         if (do_access) begin
            if (!acc_rw) begin
               mem_rdata <= (acc_addr == IO_ADDR) ? io_out : mem[acc_addr];
            end else if (acc_addr == IO_ADDR) begin
               io_out    <= acc_wdata;
               io_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: three builds (1, 0 and 3 wait states)
// driven from one initial block, expected responses queued and popped on mem_ready.
module tb_mem_bus_responder;

   logic             clk;
   logic             rst;
   logic [2:0]       req;
   logic [2:0]       rw;
   logic [2:0][7:0]  addr;
   logic [2:0][15:0] wdata;
   logic [2:0][15:0] rdata;
   logic [2:0]       ready;
   logic [2:0]       busy;
   logic [2:0][15:0] io;
   logic [2:0]       strobe;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          d;
      logic        is_read;
      logic [15:0] data;
      int          lat;
   } sb_t;

   sb_t sb[$];

   mem_bus_responder #(.WAIT_STATES(1)) dut0 (
      .clk(clk), .rst(rst), .mem_req(req[0]), .mem_rw(rw[0]), .mem_addr(addr[0]),
      .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mem_busy(busy[0]),
      .io_out(io[0]), .io_strobe(strobe[0])
   );

   mem_bus_responder #(.WAIT_STATES(0)) dut1 (
      .clk(clk), .rst(rst), .mem_req(req[1]), .mem_rw(rw[1]), .mem_addr(addr[1]),
      .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mem_busy(busy[1]),
      .io_out(io[1]), .io_strobe(strobe[1])
   );

   mem_bus_responder #(.WAIT_STATES(3)) dut2 (
      .clk(clk), .rst(rst), .mem_req(req[2]), .mem_rw(rw[2]), .mem_addr(addr[2]),
      .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ready(ready[2]), .mem_busy(busy[2]),
      .io_out(io[2]), .io_strobe(strobe[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Issues one request, scrambles the bus while it waits, and reports latency/busy/strobe counts.
   task automatic run_txn(input int d, input logic w, input logic [7:0] a, input logic [15:0] wd,
                          output int lat, output int busy_cnt, output int strobes,
                          output logic [15:0] rd);
      lat      = -1;
      busy_cnt = 0;
      strobes  = 0;
      rd       = '0;
      @(negedge clk);
      req[d]   = 1'b1;
      rw[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (busy[d]) busy_cnt++;
         if (strobe[d]) strobes++;
         if (ready[d]) begin
            lat = c;
            rd  = rdata[d];
            break;
         end
         if (c == 1) begin
            addr[d]  = a ^ 8'h5A;
            wdata[d] = ~wd;
            rw[d]    = ~w;
         end
      end
      req[d] = 1'b0;
      @(negedge clk);
      if (busy[d]) busy_cnt++;
      if (strobe[d]) strobes++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({ready[d], busy[d], strobe[d]} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl dut%0d: ready/busy/strobe=%b%b%b required 000",
                     d, ready[d], busy[d], strobe[d]);
         end
         checks++;
         if (rdata[d] !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_rdata dut%0d: got %h required 0000", d, rdata[d]);
         end
         checks++;
         if (io[d] !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_io dut%0d: got %h required 0000", d, io[d]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      int lat, bc, st;
      logic [15:0] rd, v;
      logic [7:0] a;
      sb_t e;
      for (int i = 0; i < 3; i++) begin
         a = (i == 0) ? 8'h0D : (i == 1) ? 8'h00 : 8'hFE;
         v = (i == 0) ? 16'h1234 : (i == 1) ? 16'h0F0F : 16'hF00D;
         sb.push_back('{0, 1'b0, v, 2});
         run_txn(0, 1'b1, a, v, lat, bc, st, rd);
         e = sb.pop_front();
         checks++;
         if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL wr_latency addr %h: got %0d required %0d", a, lat, e.lat);
         end
         checks++;
         if (bc !== 2) begin
            errors++;
            $display("[TB] FAIL wr_busy addr %h: got %0d cycles required 2", a, bc);
         end
         sb.push_back('{0, 1'b1, v, 2});
         run_txn(0, 1'b0, a, 16'h0000, lat, bc, st, rd);
         e = sb.pop_front();
         checks++;
         if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL rd_latency addr %h: got %0d required %0d", a, lat, e.lat);
         end
         checks++;
         if (rd !== e.data) begin
            errors++;
            $display("[TB] FAIL rd_data addr %h: got %h required %h", a, rd, e.data);
         end
         checks++;
         if (bc !== 2) begin
            errors++;
            $display("[TB] FAIL rd_busy addr %h: got %0d cycles required 2", a, bc);
         end
      end
   endtask

   task automatic test_latency();
      int lat, bc, st, d, exp_lat;
      logic [15:0] rd;
      sb_t e;
      for (int i = 0; i < 2; i++) begin
         d       = (i == 0) ? 1 : 2;
         exp_lat = (i == 0) ? 1 : 4;
         run_txn(d, 1'b1, 8'h05, 16'hBEEF, lat, bc, st, rd);
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("[TB] FAIL lat_wr dut%0d: got %0d required %0d", d, lat, exp_lat);
         end
         sb.push_back('{d, 1'b1, 16'hBEEF, exp_lat});
         run_txn(d, 1'b0, 8'h05, 16'h0000, lat, bc, st, rd);
         e = sb.pop_front();
         checks++;
         if (lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL lat_rd dut%0d: got %0d required %0d", d, lat, e.lat);
         end
         checks++;
         if (rd !== e.data) begin
            errors++;
            $display("[TB] FAIL lat_data dut%0d: got %h required %h", d, rd, e.data);
         end
         checks++;
         if (bc !== exp_lat) begin
            errors++;
            $display("[TB] FAIL lat_busy dut%0d: got %0d cycles required %0d", d, bc, exp_lat);
         end
      end
   endtask

   task automatic test_io();
      int lat, bc, st;
      logic [15:0] rd;
      sb_t e;
      sb.push_back('{0, 1'b0, 16'h00AA, 2});
      run_txn(0, 1'b1, 8'hFF, 16'h00AA, lat, bc, st, rd);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin
         errors++;
         $display("[TB] FAIL io_wr_latency: got %0d required %0d", lat, e.lat);
      end
      checks++;
      if (st !== 1) begin
         errors++;
         $display("[TB] FAIL io_strobe_count: got %0d pulses required 1", st);
      end
      checks++;
      if (io[0] !== e.data) begin
         errors++;
         $display("[TB] FAIL io_out: got %h required %h", io[0], e.data);
      end
      checks++;
      if (rdata[0] !== 16'hF00D) begin
         errors++;
         $display("[TB] FAIL io_wr_rdata_hold: got %h required F00D", rdata[0]);
      end
      checks++;
      if (dut0.mem[8'hFF] === 16'h00AA) begin
         errors++;
         $display("[TB] FAIL io_array_untouched: mem[FF]=%h must not be 00AA", dut0.mem[8'hFF]);
      end
      sb.push_back('{0, 1'b1, 16'h00AA, 2});
      run_txn(0, 1'b0, 8'hFF, 16'h0000, lat, bc, st, rd);
      e = sb.pop_front();
      checks++;
      if (rd !== e.data) begin
         errors++;
         $display("[TB] FAIL io_readback: got %h required %h", rd, e.data);
      end
      checks++;
      if (st !== 0) begin
         errors++;
         $display("[TB] FAIL io_rd_strobe: got %0d pulses required 0", st);
      end
   endtask

   task automatic test_reset_in_wait();
      int lat, bc, st;
      logic [15:0] rd;
      sb_t e;
      run_txn(2, 1'b1, 8'h20, 16'h1111, lat, bc, st, rd);
      @(negedge clk);
      req[2]   = 1'b1;
      rw[2]    = 1'b1;
      addr[2]  = 8'h20;
      wdata[2] = 16'h5555;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({ready[2], busy[2], strobe[2]} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL rstwait_ctrl: ready/busy/strobe=%b%b%b required 000",
                  ready[2], busy[2], strobe[2]);
      end
      checks++;
      if (rdata[2] !== 16'h0000 || io[2] !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL rstwait_data: rdata=%h io=%h required 0000/0000", rdata[2], io[2]);
      end
      req[2] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      checks++;
      if (dut2.mem[8'h20] !== 16'h1111) begin
         errors++;
         $display("[TB] FAIL rstwait_array: mem[20]=%h required 1111", dut2.mem[8'h20]);
      end
      sb.push_back('{2, 1'b1, 16'h1111, 4});
      run_txn(2, 1'b0, 8'h20, 16'h0000, lat, bc, st, rd);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.data) begin
         errors++;
         $display("[TB] FAIL rstwait_readback: got lat %0d data %h required lat %0d data %h",
                  lat, rd, e.lat, e.data);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc, st, gap, extra;
      logic [15:0] rd, v;
      sb_t e;
      run_txn(0, 1'b1, 8'h01, 16'hA1A1, lat, bc, st, rd);
      run_txn(0, 1'b1, 8'h02, 16'hB2B2, lat, bc, st, rd);
      run_txn(0, 1'b1, 8'h03, 16'hC3C3, lat, bc, st, rd);
      @(negedge clk);
      req[0]  = 1'b1;
      rw[0]   = 1'b0;
      addr[0] = 8'h01;
      for (int k = 0; k < 3; k++) begin
         v = (k == 0) ? 16'hA1A1 : (k == 1) ? 16'hB2B2 : 16'hC3C3;
         sb.push_back('{0, 1'b1, v, (k == 0) ? 2 : 3});
         gap = -1;
         rd  = '0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready[0]) begin
               gap = c;
               rd  = rdata[0];
               break;
            end
            if (busy[0]) addr[0] = 8'hEE;
         end
         e = sb.pop_front();
         checks++;
         if (gap !== e.lat) begin
            errors++;
            $display("[TB] FAIL b2b_spacing read %0d: got %0d cycles required %0d", k, gap, e.lat);
         end
         checks++;
         if (rd !== e.data) begin
            errors++;
            $display("[TB] FAIL b2b_data read %0d: got %h required %h", k, rd, e.data);
         end
         if (k < 2) addr[0] = 8'(k + 2);
         else req[0] = 1'b0;
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready[0]) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("[TB] FAIL b2b_extra_ready: got %0d pulses required 0", extra);
      end
   endtask

   initial begin
      rst   = 1'b1;
      req   = '0;
      rw    = '0;
      addr  = '0;
      wdata = '0;
      test_reset();
      test_write_read();
      test_latency();
      test_io();
      test_reset_in_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
